apb_requester: RTL



---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_wait_timer.sv | 29 ++
 rtl/apb_requester.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions used by apb_requester and the completer-side blocks.
package apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for APB ACCESS phases; last flags the cycle whose
// increment would reach TIMEOUT (never asserted when TIMEOUT is 0).
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (TIMEOUT > 0) && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_requester.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response
// back, with a bounded wait for PREADY.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [APB_STRB_WIDTH-1:0] cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_error,
  output logic                      rsp_timeout,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [APB_STRB_WIDTH-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PERROR
);

  localparam logic [1:0] IDLE   = APB_IDLE;
  localparam logic [1:0] SETUP  = APB_SETUP;
  localparam logic [1:0] ACCESS = APB_ACCESS;
  localparam logic [1:0] RESP   = APB_RESP;

  logic [1:0] state;
  logic       timer_clr;
  logic       timer_en;
  logic       timer_last;

  // cmd_ready is only high in IDLE, so this is exactly the accept strobe.
  assign timer_clr = cmd_valid && cmd_ready;
  assign timer_en  = (state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (timer_clr),
    .en    (timer_en),
    .last  (timer_last)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            // Misaligned commands are answered locally without touching the bus.
            if (cmd_addr[1:0] != 2'b00) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b0;
            end else begin
              state  <= SETUP;
              PSEL   <= 1'b1;
              PWRITE <= cmd_write;
              PADDR  <= cmd_addr;
              PWDATA <= cmd_wdata;
              PSTRB  <= cmd_write ? cmd_strb : '0;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          // PREADY wins over a timeout landing in the same cycle.
          if (PREADY) begin
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (!PWRITE && !PERROR) ? PRDATA : '0;
            rsp_error   <= PERROR;
            rsp_timeout <= 1'b0;
          end else if (timer_last) begin
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule
